// File: rtl/arty_io_pkg.sv
// Shared constants for the Arty board top: debouncer defaults and GPIO bit map.
package arty_io_pkg;

  localparam int unsigned DB_TICK_DIV     = 50000;
  localparam int unsigned DB_STABLE_TICKS = 10;

  localparam int unsigned N_BTN  = 4;
  localparam int unsigned N_SW   = 4;
  localparam int unsigned N_LED  = 4;
  localparam int unsigned N_RGB  = 12;
  localparam int unsigned N_CKIO = 8;

  // GPIO input bits: buttons first, then switches
  localparam int unsigned GPIO_BTN_LSB  = 0;
  localparam int unsigned GPIO_SW_LSB   = GPIO_BTN_LSB + N_BTN;
  // GPIO output bits
  localparam int unsigned GPIO_LED_LSB  = 0;
  localparam int unsigned GPIO_RGB_LSB  = GPIO_LED_LSB + N_LED;
  localparam int unsigned GPIO_CKIO_LSB = GPIO_RGB_LSB + N_RGB;

endpackage

// File: rtl/arty_input_debouncer_ch.sv
// One debounce channel: 2-flop synchroniser, tick-driven stability counter,
// debounced level and single-cycle edge pulses.
module debounce_ch #(
  parameter int unsigned STABLE_TICKS = 10,
  parameter logic        RESET_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = $clog2(STABLE_TICKS + 1);

  logic          s0_q, s1_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q   <= RESET_VAL;
      s1_q   <= RESET_VAL;
      cnt_q  <= '0;
      db_q   <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s0_q   <= raw_i;
      s1_q   <= s0_q;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // Any return of s1 to the accepted level discards progress toward a change
  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s1_q == db_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CW'(STABLE_TICKS - 1)) begin
        db_d   = s1_q;
        cnt_d  = '0;
        rise_d = s1_q;
        fall_d = ~s1_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/arty_input_debouncer.sv
// Debounces N_CH board inputs (buttons then switches) for the SoC GPIO inputs,
// sharing one free-running prescaler tick across all channels.
module arty_input_debouncer
  import arty_io_pkg::*;
#(
  parameter int unsigned N_CH         = N_BTN + N_SW,
  parameter int unsigned TICK_DIV     = DB_TICK_DIV,
  parameter int unsigned STABLE_TICKS = DB_STABLE_TICKS,
  parameter logic        RESET_VAL    = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_i,
  output logic [N_CH-1:0] db_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic            tick_o
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic          tick_q, tick_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
    end
  end

  // tick_q is a registered copy of (pre_cnt_q == TICK_DIV-1)
  always_comb begin
    pre_cnt_d = pre_cnt_q + PW'(1);
    if (pre_cnt_q == PW'(TICK_DIV - 1)) begin
      pre_cnt_d = '0;
    end
    tick_d = (pre_cnt_d == PW'(TICK_DIV - 1));
  end

  assign tick_o = tick_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_TICKS (STABLE_TICKS),
      .RESET_VAL    (RESET_VAL)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick_i (tick_q),
      .raw_i  (raw_i[i]),
      .db_o   (db_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i])
    );
  end

endmodule
